// File: rtl/uart_flow_pkg.sv
// rtl/uart_flow_pkg.sv - shared types and widths for the UART flow controller
package uart_flow_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int DROP_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CTS = 2'd1,
        START    = 2'd2,
        BUSY     = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_flow_fifo.sv
// rtl/uart_flow_fifo.sv - synchronous show-ahead FIFO with occupancy count
//
// Ports:
//   clk, reset          clock, synchronous active-high reset (empties FIFO)
//   push, push_data     write strobe and data; caller never pushes when full
//                       unless it also pops in the same cycle
//   pop                 read strobe; caller never pops when empty
//   pop_data            head entry, 0 while empty
//   count, full, empty  occupancy status
module uart_flow_fifo
    import uart_flow_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_BYTE_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_flow_ctrl.sv
// rtl/uart_flow_ctrl.sv - UART byte scheduler: RX FIFO with RTS hysteresis, CTS-gated TX launch
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cts                        asynchronous peer clear-to-send
//   rts                        request-to-send to peer (1 = we accept bytes)
//   rx_in_valid, rx_in_data    byte strobe from deserializer
//   rx_valid, rx_data,
//   rx_ready, rx_count         show-ahead FIFO head toward MMIO, pop handshake, occupancy
//   tx_valid, tx_data,
//   tx_ready                   MMIO transmit byte into the holding register
//   ser_start, ser_data,
//   ser_busy                   launch pulse / byte / busy handshake with the serializer
//   overrun, overrun_clr       sticky drop flag and its clear (a drop wins over clear)
//   rx_drop_cnt                saturating dropped-byte count, present only when
//                              UART_FLOW_STATS_EN is defined
module uart_flow_ctrl
    import uart_flow_pkg::*;
#(
    parameter int RX_DEPTH   = 16,
    parameter int HIGH_WATER = 12,
    parameter int LOW_WATER  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cts,
    output logic                        rts,
    input  logic                        rx_in_valid,
    input  logic [UART_BYTE_W-1:0]      rx_in_data,
    output logic                        rx_valid,
    output logic [UART_BYTE_W-1:0]      rx_data,
    input  logic                        rx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    input  logic                        tx_valid,
    input  logic [UART_BYTE_W-1:0]      tx_data,
    output logic                        tx_ready,
    output logic                        ser_start,
    output logic [UART_BYTE_W-1:0]      ser_data,
    input  logic                        ser_busy,
    output logic                        overrun,
    input  logic                        overrun_clr
`ifdef UART_FLOW_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0]       rx_drop_cnt
`endif
);

    localparam int CW = $clog2(RX_DEPTH) + 1;

    // ---------------- CTS synchronizer ----------------
    logic cts_m;
    logic cts_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            cts_m <= 1'b0;
            cts_s <= 1'b0;
        end else begin
            cts_m <= cts;
            cts_s <= cts_m;
        end
    end

    // ---------------- RX FIFO ----------------
    logic          rx_full;
    logic          rx_empty;
    logic          rx_pop;
    logic          rx_push;
    logic          rx_drop;
    logic [CW-1:0] rx_count_next;

    assign rx_pop  = rx_valid & rx_ready;
    // A pop frees the slot in the same cycle, so a push at full is still taken.
    assign rx_push = rx_in_valid & (~rx_full | rx_pop);
    assign rx_drop = rx_in_valid & rx_full & ~rx_pop;

    uart_flow_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (UART_BYTE_W)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_in_data),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign rx_valid = ~rx_empty;

    always_comb begin
        rx_count_next = rx_count;
        if (rx_push && !rx_pop) begin
            rx_count_next = rx_count + CW'(1);
        end else if (rx_pop && !rx_push) begin
            rx_count_next = rx_count - CW'(1);
        end
    end

    // RTS follows the upcoming occupancy so the peer is throttled on the same
    // edge the threshold is crossed; the band in between holds the last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rts <= 1'b0;
        end else if (rx_count_next >= CW'(HIGH_WATER)) begin
            rts <= 1'b0;
        end else if (rx_count_next <= CW'(LOW_WATER)) begin
            rts <= 1'b1;
        end
    end

    // ---------------- overrun / statistics ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (rx_drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_FLOW_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_drop_cnt <= '0;
        end else if (rx_drop) begin
            if (overrun_clr) begin
                rx_drop_cnt <= DROP_CNT_W'(1);
            end else if (rx_drop_cnt != '1) begin
                rx_drop_cnt <= rx_drop_cnt + DROP_CNT_W'(1);
            end
        end else if (overrun_clr) begin
            rx_drop_cnt <= '0;
        end
    end
`endif

    // ---------------- TX FSM ----------------
    tx_state_e state;
    tx_state_e state_next;
    logic      tx_load;
    logic      out_of_reset;

    // Keeps tx_ready low while reset is held; it rises on the first free cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_ready   = 1'b0;
        ser_start  = 1'b0;
        tx_load    = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = out_of_reset;
                if (out_of_reset && tx_valid) begin
                    tx_load    = 1'b1;
                    state_next = WAIT_CTS;
                end
            end
            WAIT_CTS: begin
                if (cts_s && !ser_busy) begin
                    state_next = START;
                end
            end
            START: begin
                ser_start  = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                // CTS is deliberately not looked at here: a byte in flight completes.
                if (!ser_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ser_data <= '0;
        end else if (tx_load) begin
            ser_data <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_flow_ctrl.sv
// tb/tb_uart_flow_ctrl.sv - self-checking bench for uart_flow_ctrl
module tb_uart_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cts = 1'b0;
    logic       rts;
    logic       rx_in_valid = 1'b0;
    logic [7:0] rx_in_data = 8'h00;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic [4:0] rx_count;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       ser_start;
    logic [7:0] ser_data;
    logic       ser_busy;
    logic       overrun;
    logic       overrun_clr = 1'b0;
`ifdef UART_FLOW_STATS_EN
    logic [15:0] rx_drop_cnt;
`endif

    uart_flow_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cts         (cts),
        .rts         (rts),
        .rx_in_valid (rx_in_valid),
        .rx_in_data  (rx_in_data),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_count    (rx_count),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ser_start   (ser_start),
        .ser_data    (ser_data),
        .ser_busy    (ser_busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef UART_FLOW_STATS_EN
        ,
        .rx_drop_cnt (rx_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Serializer model: busy for 10 cycles starting the cycle after ser_start.
    int busy_cnt = 0;
    int start_pulses = 0;
    always @(posedge clk) begin
        if (reset) busy_cnt <= 0;
        else if (ser_start) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (!reset && ser_start) start_pulses <= start_pulses + 1;
    end
    assign ser_busy = (busy_cnt != 0);

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       push;
        logic [7:0] din;
        logic       pop;
        logic       clr;
        int         cnt;
        logic       vld;
        logic [7:0] dat;
        logic       rts;
        logic       ovr;
    } vec_t;
    vec_t vecs[$];
    logic [7:0] drain_seq[16];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        rx_in_valid = 1'b0;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        overrun_clr = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic wait_ser_idle;
        int n;
        n = 0;
        while (ser_busy && n < 50) begin
            tick;
            n++;
        end
        if (ser_busy) begin
            checks++;
            errors++;
            $display("FAIL ser_busy_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_in_valid = 1'b1;
        rx_in_data = d;
        tick;
        rx_in_valid = 1'b0;
    endtask

    function automatic void add(input logic push, input logic [7:0] din, input logic pop,
                                input logic clr, input int cnt, input logic vld,
                                input logic [7:0] dat, input logic r, input logic ovr);
        vec_t v;
        v.push = push; v.din = din; v.pop = pop; v.clr = clr;
        v.cnt = cnt; v.vld = vld; v.dat = dat; v.rts = r; v.ovr = ovr;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        // ---------------- reset state ----------------
        reset = 1'b1;
        tick;
        tick;
        chk("rst_rts", rts, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_ser_start", ser_start, 0);
        chk("rst_ser_data", ser_data, 0);
        chk("rst_overrun", overrun, 0);
        reset = 1'b0;
        tick;
        chk("rel_tx_ready", tx_ready, 1);
        chk("rel_rts", rts, 1);

        // ---------------- test 1: basic transmit ----------------
        cts = 1'b1;
        tick; tick; tick;
        p0 = start_pulses;
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        tick;
        tx_valid = 1'b0;
        chk("t1_tx_ready_busy", tx_ready, 0);
        chk("t1_ser_data", ser_data, 8'hA5);
        chk("t1_no_start_yet", ser_start, 0);
        tick;
        chk("t1_ser_start", ser_start, 1);
        tick;
        chk("t1_start_one_cycle", ser_start, 0);
        chk("t1_ser_busy", ser_busy, 1);
        wait_ser_idle;
        chk("t1_tx_ready_at_fall", tx_ready, 0);
        chk("t1_ser_data_stable", ser_data, 8'hA5);
        tick;
        chk("t1_tx_ready_after", tx_ready, 1);
        chk("t1_pulses", start_pulses - p0, 1);

        // ---------------- test 2: CTS gating ----------------
        cts = 1'b0;
        tick; tick; tick;
        p0 = start_pulses;
        tx_valid = 1'b1;
        tx_data = 8'h3C;
        tick;
        tx_valid = 1'b0;
        repeat (6) tick;
        chk("t2_parked_no_start", start_pulses - p0, 0);
        chk("t2_parked_tx_ready", tx_ready, 0);
        cts = 1'b1;
        tick;
        chk("t2_lat1", ser_start, 0);
        tick;
        chk("t2_lat2", ser_start, 0);
        tick;
        chk("t2_lat3_start", ser_start, 1);
        tick;
        cts = 1'b0;
        chk("t2_busy", ser_busy, 1);
        tick; tick; tick;
        chk("t2_cts_drop_tx_ready", tx_ready, 0);
        chk("t2_cts_drop_data", ser_data, 8'h3C);
        wait_ser_idle;
        chk("t2_tx_ready_at_fall", tx_ready, 0);
        tick;
        chk("t2_tx_ready_after", tx_ready, 1);
        chk("t2_pulses", start_pulses - p0, 1);
        // back-to-back accept in the first IDLE cycle
        tx_valid = 1'b1;
        tx_data = 8'h5A;
        tick;
        tx_valid = 1'b0;
        chk("t2_b2b_accept", tx_ready, 0);
        chk("t2_b2b_data", ser_data, 8'h5A);

        // ---------------- tests 3/4: RX FIFO table ----------------
        do_reset;
        for (int i = 0; i < 12; i++)
            add(1, 8'h10 + 8'(i), 0, 0, i + 1, 1, 8'h10, (i + 1 >= 12) ? 1'b0 : 1'b1, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 8'h00, 1, 0, 12 - k, 1, 8'h10 + 8'(k), (12 - k <= 4) ? 1'b1 : 1'b0, 0);
        for (int j = 0; j < 12; j++)
            add(1, 8'h20 + 8'(j), 0, 0, 5 + j, 1, 8'h18, (5 + j >= 12) ? 1'b0 : 1'b1, 0);
        add(1, 8'hFF, 0, 0, 16, 1, 8'h18, 0, 1);   // drop at full
        add(0, 8'h00, 0, 1, 16, 1, 8'h18, 0, 0);   // clear overrun
        add(1, 8'hEE, 1, 0, 16, 1, 8'h19, 0, 0);   // push+pop at full
        for (int i = 0; i < 3; i++) drain_seq[i] = 8'h19 + 8'(i);
        for (int j = 0; j < 12; j++) drain_seq[3 + j] = 8'h20 + 8'(j);
        drain_seq[15] = 8'hEE;
        for (int m = 1; m <= 16; m++)
            add(0, 8'h00, 1, 0, 16 - m, (m < 16) ? 1'b1 : 1'b0,
                (m < 16) ? drain_seq[m] : 8'h00, (16 - m <= 4) ? 1'b1 : 1'b0, 0);

        foreach (vecs[i]) begin
            rx_in_valid = vecs[i].push;
            rx_in_data = vecs[i].din;
            rx_ready = vecs[i].pop;
            overrun_clr = vecs[i].clr;
            tick;
            rx_in_valid = 1'b0;
            rx_ready = 1'b0;
            overrun_clr = 1'b0;
            chk($sformatf("v%0d_count", i), rx_count, vecs[i].cnt);
            chk($sformatf("v%0d_valid", i), rx_valid, vecs[i].vld);
            chk($sformatf("v%0d_data", i), rx_data, vecs[i].dat);
            chk($sformatf("v%0d_rts", i), rts, vecs[i].rts);
            chk($sformatf("v%0d_overrun", i), overrun, vecs[i].ovr);
        end

        // ---------------- overrun clear vs drop, statistics ----------------
        do_reset;
        for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
        for (int i = 0; i < 3; i++) push_byte(8'hD0);
        chk("ovr_set", overrun, 1);
        chk("ovr_count_full", rx_count, 16);
        chk("ovr_head_intact", rx_data, 8'h40);
`ifdef UART_FLOW_STATS_EN
        chk("stats_three_drops", rx_drop_cnt, 3);
`endif
        overrun_clr = 1'b1;
        push_byte(8'hD1);
        overrun_clr = 1'b0;
        chk("ovr_set_wins_clr", overrun, 1);
`ifdef UART_FLOW_STATS_EN
        chk("stats_drop_wins_clr", rx_drop_cnt, 1);
`endif
        overrun_clr = 1'b1;
        tick;
        overrun_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);
`ifdef UART_FLOW_STATS_EN
        chk("stats_cleared", rx_drop_cnt, 0);
`endif

        // ---------------- test 6: reset mid-operation ----------------
        do_reset;
        for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
        chk("t6_queued", rx_count, 5);
        cts = 1'b1;
        tick; tick; tick;
        tx_valid = 1'b1;
        tx_data = 8'h77;
        tick;
        tx_valid = 1'b0;
        tick;
        tick;
        chk("t6_in_busy", ser_busy, 1);
        p0 = start_pulses;
        reset = 1'b1;
        tick;
        chk("t6_rx_count", rx_count, 0);
        chk("t6_rx_valid", rx_valid, 0);
        chk("t6_ser_start", ser_start, 0);
        chk("t6_ser_data", ser_data, 0);
        chk("t6_rts", rts, 0);
        reset = 1'b0;
        tick;
        chk("t6_idle_tx_ready", tx_ready, 1);
        tick;
        tick;
        chk("t6_no_relaunch", start_pulses - p0, 0);
        chk("t6_rx_count_after", rx_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
